// File: rtl/inst_mem_pipelined.sv
// inst_mem_pipelined: RAM-backed instruction memory with a 1-cycle registered fetch, valid/ready handshake and run-time load port.
// Define IMEM_BOUNDS_CHECK_EN to fault misaligned/out-of-range fetches instead of wrapping the address.
module inst_mem_pipelined #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_inst,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_fault,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_last,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [DEPTH_LOG2:0]   load_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;

    typedef enum logic {RUN, LOAD} state_t;
    state_t r_state, w_next;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: NOP_WORD};
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_done, r_rsp_valid, r_rsp_fault;
    logic [DATA_WIDTH-1:0] r_rsp_inst;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic                  w_drained, w_accept, w_enter, w_write, w_exit, w_fault;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_idx = req_addr[DEPTH_LOG2+1:2];
`ifdef IMEM_BOUNDS_CHECK_EN
    assign w_fault = (|req_addr[1:0]) || (|req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]);
`else
    logic w_unused;
    assign w_fault = 1'b0;
    assign w_unused = ^{req_addr[1:0], req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]};
`endif

    // Loading and fetching never overlap: LOAD is only entered once the response slot is free.
    assign w_drained = !r_rsp_valid || rsp_ready;
    assign req_ready = (r_state == RUN) && !load_start && w_drained;
    assign w_accept  = req_valid && req_ready;
    assign w_enter   = (r_state == RUN) && load_start && w_drained;
    assign w_write   = (r_state == LOAD) && load_valid;
    assign w_exit    = w_write && (load_last || &r_ptr);

    always_comb begin
        w_next = w_enter ? LOAD : w_exit ? RUN : r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_ptr   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_exit;
            if (w_enter) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_write) begin
                r_ptr   <= r_ptr + DEPTH_LOG2'(1);
                r_count <= r_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write && !reset)
            r_mem[r_ptr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_inst  <= NOP_WORD;
            r_rsp_addr  <= '0;
            r_rsp_fault <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_inst  <= w_fault ? NOP_WORD : r_mem[w_idx];
            r_rsp_addr  <= req_addr;
            r_rsp_fault <= w_fault;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_inst   = r_rsp_inst;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_fault  = r_rsp_fault;
    assign load_busy  = (r_state == LOAD);
    assign load_done  = r_done;
    assign load_count = r_count;
endmodule

// File: tb/tb_inst_mem_pipelined.sv
// tb_inst_mem_pipelined: directed scenarios plus random traffic checked against a queue/array model of the fetch memory.
module tb_inst_mem_pipelined;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_fault;
    logic [31:0] req_addr = '0, rsp_inst, rsp_addr, load_data = '0;
    logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0, load_busy, load_done;
    logic [8:0]  load_count;

    always #5 clk = ~clk;

    inst_mem_pipelined dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
        .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_busy(load_busy), .load_done(load_done),
        .load_count(load_count)
    );

    typedef struct {logic [31:0] addr; logic [31:0] inst; logic fault;} rsp_t;
    rsp_t        q[$];
    logic [31:0] mm [256];
    int          checks = 0, errors = 0;
    bit          m_load, m_done;
    int          m_ptr, m_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rsp_t exp_of(input logic [31:0] a);
        rsp_t r;
        r.addr = a;
        r.fault = 1'b0;
        r.inst = mm[a[9:2]];
`ifdef IMEM_BOUNDS_CHECK_EN
        if (a[1:0] != 2'b00 || a >= 32'd1024) begin
            r.fault = 1'b1;
            r.inst = '0;
        end
`endif
        return r;
    endfunction

    task automatic cyc(input logic rv, input logic [31:0] ra, input logic rr, input logic ls,
                       input logic lv, input logic ll, input logic [31:0] ld);
        bit pend, exp_rdy;
        req_valid = rv; req_addr = ra; rsp_ready = rr;
        load_start = ls; load_valid = lv; load_last = ll; load_data = ld;
        #1;
        pend = q.size() != 0;
        check("load_busy", 64'(load_busy), 64'(m_load));
        check("load_done", 64'(load_done), 64'(m_done));
        check("load_count", 64'(load_count), 64'(m_count));
        check("rsp_valid", 64'(rsp_valid), 64'(pend));
        if (pend) begin
            check("rsp_addr", 64'(rsp_addr), 64'(q[0].addr));
            check("rsp_inst", 64'(rsp_inst), 64'(q[0].inst));
            check("rsp_fault", 64'(rsp_fault), 64'(q[0].fault));
        end
        exp_rdy = !m_load && !ls && (!pend || rr);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        m_done = 1'b0;
        if (pend && rr) void'(q.pop_front());
        if (rv && exp_rdy) q.push_back(exp_of(ra));
        if (!m_load) begin
            if (ls && (!pend || rr)) begin
                m_load = 1'b1; m_ptr = 0; m_count = 0;
            end
        end else if (lv) begin
            mm[m_ptr] = ld;
            m_count++;
            if (ll || m_ptr == 255) begin
                m_load = 1'b0; m_done = 1'b1;
            end
            m_ptr++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic fetch(input logic [31:0] a);
        cyc(1'b1, a, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_load = 1'b0; m_done = 1'b0; m_count = 0; m_ptr = 0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_inst", 64'(rsp_inst), 64'(0));
        check("rst_rsp_addr", 64'(rsp_addr), 64'(0));
        check("rst_rsp_fault", 64'(rsp_fault), 64'(0));
        check("rst_load_busy", 64'(load_busy), 64'(0));
        check("rst_load_done", 64'(load_done), 64'(0));
        check("rst_load_count", 64'(load_count), 64'(0));
    endtask

    initial begin
        logic [31:0] w5;
        for (int i = 0; i < 256; i++) mm[i] = '0;
        @(negedge clk);
        do_reset();

        fetch(32'h0);
        check("t1_inst", 64'(rsp_inst), 64'(0));
        check("t1_valid", 64'(rsp_valid), 64'(1));
        idle(1);

        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8c080000);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8c090004);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0810001a);
        check("t2_done", 64'(load_done), 64'(1));
        check("t2_count", 64'(load_count), 64'(3));
        idle(1);
        fetch(32'h8);
        check("t2_inst", 64'(rsp_inst), 64'(32'h0810001a));
        idle(1);

        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        idle(2);

        cyc(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (4) cyc(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("t4_busy", 64'(load_busy), 64'(1));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111);
        idle(2);

        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 256; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        check("t5_count", 64'(load_count), 64'(256));
        idle(1);
        fetch(32'h400);
        fetch(32'h2);
        idle(2);

        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        w5 = mm[4];
        do_reset();
        idle(2);
        fetch(32'h10);
        check("t6_inst", 64'(rsp_inst), 64'(w5));
        idle(1);

        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a = (sel < 8) ? {22'd0, 8'($urandom_range(0, 255)), 2'b00} :
                (sel == 8) ? ($urandom & 32'hfff) : $urandom;
            cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0,
                $urandom_range(0, 30) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7) == 0, $urandom);
        end
        repeat (300) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, $urandom);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
